som_sweep_ctrl: RTL and testbench

- Upstream stimulus and response checker for the SOP decoder stage that computes F = A(CD + B) + BC'. F is built from a 2x4 positive-output, positive-enable decoder.
- On a start pulse, sweeps all 16 ABCD input combinations twice: first with the enable low, then with the enable high.
- Captures the DUT's F for every vector into two 16-bit truth-table maps and compares each map to a golden value.
- Reports a pass/fail flag and a mismatch count. Used as the self-checking front end for the decoder stage in hardware and in simulation.

---
 rtl/som_sweep_ctrl.sv | 160 ++++++++++++++++
 tb/tb_som_sweep_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/som_sweep_ctrl.sv
// Stimulus sweeper and truth-table checker for the F = A(CD+B)+BC' decoder stage.
// Optional macro SOM_SWEEP_FIRST_FAIL_EN adds the first_fail output {phase, valid, vec}.
module som_sweep_ctrl #(
  parameter int          HOLD       = 2,
  parameter logic [15:0] GOLDEN_EN  = 16'hF830,
  parameter logic [15:0] GOLDEN_DIS = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f_in,
  output logic        a_out,
  output logic        b_out,
  output logic        c_out,
  output logic        d_out,
  output logic        en_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [5:0]  mismatch_cnt,
  output logic [15:0] f_map_dis,
  output logic [15:0] f_map_en
`ifdef SOM_SWEEP_FIRST_FAIL_EN
  ,
  output logic [5:0]  first_fail
`endif
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SWEEP_DIS = 2'd1;
  localparam logic [1:0] SWEEP_EN  = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  vec_q, vec_d;
  logic [3:0]  hold_q, hold_d;
  logic        en_q, en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] map_dis_q, map_dis_d;
  logic [15:0] map_en_q, map_en_d;
  logic [5:0]  ff_q, ff_d;
  logic        golden_bit;

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    hold_d     = hold_q;
    en_d       = en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    cnt_d      = cnt_q;
    map_dis_d  = map_dis_q;
    map_en_d   = map_en_q;
    ff_d       = ff_q;
    golden_bit = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SWEEP_DIS;
          vec_d     = 4'd0;
          hold_d    = 4'd0;
          en_d      = 1'b0;
          busy_d    = 1'b1;
          pass_d    = 1'b0;
          cnt_d     = 6'd0;
          map_dis_d = 16'h0000;
          map_en_d  = 16'h0000;
          ff_d      = 6'd0;
        end
      end
      SWEEP_DIS, SWEEP_EN: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = 4'd0;
          vec_d  = vec_q + 4'd1;
          if (state_q == SWEEP_EN) begin
            golden_bit      = GOLDEN_EN[vec_q];
            map_en_d[vec_q] = f_in;
          end else begin
            golden_bit       = GOLDEN_DIS[vec_q];
            map_dis_d[vec_q] = f_in;
          end
          if (f_in != golden_bit) begin
            if (cnt_q != 6'd32) cnt_d = cnt_q + 6'd1;
            if (!ff_q[4]) ff_d = {en_q, 1'b1, vec_q};
          end
          // Pass is taken from the count including this final sample so it lines up with done.
          if (vec_q == 4'd15) begin
            if (state_q == SWEEP_DIS) begin
              state_d = SWEEP_EN;
              en_d    = 1'b1;
            end else begin
              state_d = DONE;
              en_d    = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (cnt_d == 6'd0);
            end
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_q     <= 4'd0;
      hold_q    <= 4'd0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      cnt_q     <= 6'd0;
      map_dis_q <= 16'h0000;
      map_en_q  <= 16'h0000;
      ff_q      <= 6'd0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      hold_q    <= hold_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      cnt_q     <= cnt_d;
      map_dis_q <= map_dis_d;
      map_en_q  <= map_en_d;
      ff_q      <= ff_d;
    end
  end

  assign {a_out, b_out, c_out, d_out} = vec_q;
  assign en_out       = en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign mismatch_cnt = cnt_q;
  assign f_map_dis    = map_dis_q;
  assign f_map_en     = map_en_q;

`ifdef SOM_SWEEP_FIRST_FAIL_EN
  assign first_fail = ff_q;
`else
  logic unused_ff;
  assign unused_ff = ^ff_q;
`endif

endmodule

// File: tb/tb_som_sweep_ctrl.sv
// Scoreboard bench for som_sweep_ctrl: HOLD=2 instance with a switchable decoder-stage
// model (good / stuck-at-1 / enable ignored) and a HOLD=1 instance driving a good stage.
module tb_som_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start0, start1;
  int   mode;
  logic f0, f1;

  logic        a0, b0, c0, d0, en0, busy0, done0, pass0;
  logic [5:0]  cnt0;
  logic [15:0] dis0, enm0;
  logic        a1, b1, c1, d1, en1, busy1, done1, pass1;
  logic [5:0]  cnt1;
  logic [15:0] dis1, enm1;
`ifdef SOM_SWEEP_FIRST_FAIL_EN
  logic [5:0]  ff0, ff1;
`endif

  typedef struct {
    int          done_cyc;
    logic [15:0] dis;
    logic [15:0] en;
    logic [5:0]  cnt;
    logic        pass;
    logic [5:0]  ff;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, e1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Decoder-stage model: 0 = good (gated by E), 1 = stuck at 1, 2 = enable ignored
  function automatic logic stage_f(logic a, logic b, logic c, logic d, logic e, int m);
    logic y;
    y = (a & ((c & d) | b)) | (b & ~c);
    case (m)
      0:       return e & y;
      1:       return 1'b1;
      default: return y;
    endcase
  endfunction

  assign f0 = stage_f(a0, b0, c0, d0, en0, mode);
  assign f1 = stage_f(a1, b1, c1, d1, en1, 0);

  som_sweep_ctrl #(.HOLD(2)) u0 (
    .clk(clk), .rst(rst), .start(start0), .f_in(f0),
    .a_out(a0), .b_out(b0), .c_out(c0), .d_out(d0), .en_out(en0),
    .busy(busy0), .done(done0), .pass(pass0), .mismatch_cnt(cnt0),
    .f_map_dis(dis0), .f_map_en(enm0)
`ifdef SOM_SWEEP_FIRST_FAIL_EN
    , .first_fail(ff0)
`endif
  );

  som_sweep_ctrl #(.HOLD(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .f_in(f1),
    .a_out(a1), .b_out(b1), .c_out(c1), .d_out(d1), .en_out(en1),
    .busy(busy1), .done(done1), .pass(pass1), .mismatch_cnt(cnt1),
    .f_map_dis(dis1), .f_map_en(enm1)
`ifdef SOM_SWEEP_FIRST_FAIL_EN
    , .first_fail(ff1)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pulses start on one instance and queues the response expected at its done pulse.
  task automatic applyStimulus(input int which, input int m, input logic [15:0] edis,
                               input logic [15:0] een, input logic [5:0] ecnt,
                               input logic epass, input logic [5:0] eff, input int hold);
    exp_t e;
    if (which == 0) mode = m;
    @(negedge clk);
    if (which == 0) start0 = 1'b1;
    else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    e.done_cyc = cyc + 32 * hold;
    e.dis  = edis;
    e.en   = een;
    e.cnt  = ecnt;
    e.pass = epass;
    e.ff   = eff;
    if (which == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endtask

  task automatic wait_idle(input int which);
    int k;
    k = 0;
    while (((which == 0) ? sb0.size() : sb1.size()) != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (((which == 0) ? sb0.size() : sb1.size()) != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL done timeout on u%0d: got no done, expected done", which);
      if (which == 0) sb0.delete();
      else sb1.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && done0) begin
      if (sb0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL u0 unexpected done: got done=1 at cycle %0d, expected none", cyc);
      end else begin
        e0 = sb0.pop_front();
        checkOutput("u0 done cycle", cyc, e0.done_cyc);
        checkOutput("u0 f_map_dis", {16'h0, dis0}, {16'h0, e0.dis});
        checkOutput("u0 f_map_en", {16'h0, enm0}, {16'h0, e0.en});
        checkOutput("u0 mismatch_cnt", {26'h0, cnt0}, {26'h0, e0.cnt});
        checkOutput("u0 pass", {31'h0, pass0}, {31'h0, e0.pass});
        checkOutput("u0 busy at done", {31'h0, busy0}, 32'h0);
`ifdef SOM_SWEEP_FIRST_FAIL_EN
        checkOutput("u0 first_fail", {26'h0, ff0}, {26'h0, e0.ff});
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done1) begin
      if (sb1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL u1 unexpected done: got done=1 at cycle %0d, expected none", cyc);
      end else begin
        e1 = sb1.pop_front();
        checkOutput("u1 done cycle", cyc, e1.done_cyc);
        checkOutput("u1 f_map_dis", {16'h0, dis1}, {16'h0, e1.dis});
        checkOutput("u1 f_map_en", {16'h0, enm1}, {16'h0, e1.en});
        checkOutput("u1 mismatch_cnt", {26'h0, cnt1}, {26'h0, e1.cnt});
        checkOutput("u1 pass", {31'h0, pass1}, {31'h0, e1.pass});
`ifdef SOM_SWEEP_FIRST_FAIL_EN
        checkOutput("u1 first_fail", {26'h0, ff1}, {26'h0, e1.ff});
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    mode   = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset stim/flags", {24'h0, a0, b0, c0, d0, en0, busy0, done0, pass0}, 32'h0);
    checkOutput("reset mismatch_cnt", {26'h0, cnt0}, 32'h0);
    checkOutput("reset maps", {enm0, dis0}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] good stage, HOLD=2");
    applyStimulus(0, 0, 16'h0000, 16'hF830, 6'd0, 1'b1, 6'b000000, 2);
    wait_idle(0);

    $display("[TB] stuck-at-1 stage");
    applyStimulus(0, 1, 16'hFFFF, 16'hFFFF, 6'd25, 1'b0, 6'b010000, 2);
    wait_idle(0);
    checkOutput("pass held after sweep", {31'h0, pass0}, 32'h0);

    $display("[TB] stage ignoring enable");
    applyStimulus(0, 2, 16'hF830, 16'hF830, 6'd7, 1'b0, 6'b010100, 2);
    wait_idle(0);

    $display("[TB] start pulses during sweep");
    applyStimulus(0, 0, 16'h0000, 16'hF830, 6'd0, 1'b1, 6'b000000, 2);
    repeat (3) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (34) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_idle(0);
    repeat (70) @(negedge clk);
    checkOutput("single sweep busy", {31'h0, busy0}, 32'h0);

    $display("[TB] reset mid-sweep");
    applyStimulus(0, 1, 16'hFFFF, 16'hFFFF, 6'd25, 1'b0, 6'b010000, 2);
    repeat (28) @(negedge clk);
    sb0.delete();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid reset stim/flags", {24'h0, a0, b0, c0, d0, en0, busy0, done0, pass0}, 32'h0);
    checkOutput("mid reset mismatch_cnt", {26'h0, cnt0}, 32'h0);
    checkOutput("mid reset maps", {enm0, dis0}, 32'h0);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    applyStimulus(0, 0, 16'h0000, 16'hF830, 6'd0, 1'b1, 6'b000000, 2);
    wait_idle(0);

    $display("[TB] good stage, HOLD=1, vector order");
    applyStimulus(1, 0, 16'h0000, 16'hF830, 6'd0, 1'b1, 6'b000000, 1);
    for (int step = 0; step < 32; step++) begin
      checkOutput("u1 stimulus step", {26'h0, busy1, en1, a1, b1, c1, d1},
                  {26'h0, 1'b1, 5'(step)});
      @(negedge clk);
    end
    wait_idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
